// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serializer/deserializer pair.
// Holds the bit-order enum and the bit-counter width function.
package s2p_pkg;

    typedef enum logic {
        S2P_LSB_FIRST = 1'b0,
        S2P_MSB_FIRST = 1'b1
    } s2p_order_e;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/s2p_hold_reg.sv
// One-entry valid/ready holding register; loads when empty or draining, 1-cycle latency.
// Backpressure: a load while full and not draining is dropped and flagged on drop.
module s2p_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             drop
);

    logic take;

    // The held word may be replaced in the same cycle it is handed off, so there is no bubble.
    assign take = in_vld && (!out_vld || out_rdy);
    assign drop = in_vld && out_vld && !out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (take) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer: gathers WIDTH valid-qualified bits into a word; pvalid_o one cycle after last bit.
// Backpressure: none on valid_i; a word completing while the held word is stalled is dropped (sticky overflow_o).
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             pvalid_o,
    input  logic             pready_i,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int                CW    = cnt_w(WIDTH);
    localparam s2p_order_e        ORDER = (MSB_FIRST != 0) ? S2P_MSB_FIRST : S2P_LSB_FIRST;
    localparam logic [CW-1:0]     LAST  = CW'(WIDTH - 1);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             complete;
    logic             drop;

    always_comb begin
        sr_nxt = sr;
        if (ORDER == S2P_MSB_FIRST) begin
            sr_nxt = {sr[WIDTH-2:0], serial_i};
        end else begin
            sr_nxt = {serial_i, sr[WIDTH-1:1]};
        end
    end

    assign complete = valid_i && (count == LAST);
    assign empty_o  = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (valid_i) begin
            count <= complete ? '0 : count + CW'(1);
        end
    end

    // No clear on completion: the next WIDTH captures fully overwrite the stale bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (valid_i) begin
            sr <= sr_nxt;
        end
    end

    s2p_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (complete),
        .in_dat  (sr_nxt),
        .out_vld (pvalid_o),
        .out_rdy (pready_i),
        .out_dat (parallel_o),
        .drop    (drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end
    end

endmodule
